// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit: condition codes,
// ALU op encodings, FSM states and the condition-table helper.
package branch_resolve_unit_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    BR_BEQ = 3'b000,
    BR_BNE = 3'b001,
    BR_BGT = 3'b010,
    BR_BLT = 3'b011,
    BR_BGE = 3'b100,
    BR_BLE = 3'b101,
    BR_JMP = 3'b110,
    BR_NOP = 3'b111
  } br_op_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_TGT  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // zero/pos describe the wrapped difference a-b from the compare pass.
  function automatic logic cond_taken(input br_op_e op, input logic zero, input logic pos);
    logic taken;
    case (op)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      BR_BGT:  taken = pos;
      BR_BLT:  taken = !zero && !pos;
      BR_BGE:  taken = zero || pos;
      BR_BLE:  taken = !pos;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // JMP and NOP resolve without a compare pass.
  function automatic logic needs_compare(input br_op_e op);
    return !(op == BR_JMP || op == BR_NOP);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational map from condition code and compare flags to taken.
module br_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] op,
  input  logic       zero,
  input  logic       pos,
  output logic       taken
);

  logic [7:0] taken_vec;

  // One decoded outcome per condition code, then select by op.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cond
      assign taken_vec[gi] = cond_taken(br_op_e'(3'(gi)), zero, pos);
    end
  endgenerate

  assign taken = taken_vec[op];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolver driving an external add/subtract ALU: a compare pass (a-b)
// followed by a target pass (pc+off), then a held valid/ready response.
module branch_resolve_unit #(
  parameter int WIDTH   = branch_resolve_unit_pkg::WIDTH,
  parameter int PC_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_pc,
  input  logic [WIDTH-1:0] req_off,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [WIDTH-1:0] resp_next_pc,
  output logic             alu_inst_id,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic             alu_reset,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_zero,
  input  logic [WIDTH-1:0] alu_pos
);
  import branch_resolve_unit_pkg::*;

  state_e           state_reg, state_next;
  br_op_e           op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] off_reg, off_next;
  logic [WIDTH-1:0] next_pc_reg, next_pc_next;
  logic             zero_reg, zero_next;
  logic             pos_reg, pos_next;
  logic             taken_reg, taken_next;

  logic             eval_taken;
  logic [WIDTH-1:0] fall_through;
  logic             unused_flag_bits;

  // The ALU flags are full-width buses but only bit 0 carries information.
  assign unused_flag_bits = ^{alu_zero[WIDTH-1:1], alu_pos[WIDTH-1:1]};

  assign fall_through = pc_reg + WIDTH'(PC_STEP);
  assign alu_reset    = reset;

  br_cond_eval u_cond_eval (
    .op    (op_reg),
    .zero  (zero_reg),
    .pos   (pos_reg),
    .taken (eval_taken)
  );

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    pc_next      = pc_reg;
    off_next     = off_reg;
    zero_next    = zero_reg;
    pos_next     = pos_reg;
    taken_next   = taken_reg;
    next_pc_next = next_pc_reg;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_taken   = 1'b0;
    resp_next_pc = '0;
    alu_inst_id  = ALU_ADD;
    alu_in0      = '0;
    alu_in1      = '0;

    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_next    = br_op_e'(req_op);
          a_next     = req_a;
          b_next     = req_b;
          pc_next    = req_pc;
          off_next   = req_off;
          state_next = needs_compare(br_op_e'(req_op)) ? ST_CMP : ST_TGT;
        end
      end
      ST_CMP: begin
        alu_inst_id = ALU_SUB;
        alu_in0     = a_reg;
        alu_in1     = b_reg;
        zero_next   = alu_zero[0];
        pos_next    = alu_pos[0];
        state_next  = ST_TGT;
      end
      ST_TGT: begin
        // Flags are stale for JMP/NOP, but the evaluator ignores them there.
        alu_inst_id  = ALU_ADD;
        alu_in0      = pc_reg;
        alu_in1      = off_reg;
        taken_next   = eval_taken;
        next_pc_next = eval_taken ? alu_out : fall_through;
        state_next   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid   = 1'b1;
        resp_taken   = taken_reg;
        resp_next_pc = next_pc_reg;
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      op_reg      <= BR_BEQ;
      a_reg       <= '0;
      b_reg       <= '0;
      pc_reg      <= '0;
      off_reg     <= '0;
      zero_reg    <= 1'b0;
      pos_reg     <= 1'b0;
      taken_reg   <= 1'b0;
      next_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      pc_reg      <= pc_next;
      off_reg     <= off_next;
      zero_reg    <= zero_next;
      pos_reg     <= pos_next;
      taken_reg   <= taken_next;
      next_pc_reg <= next_pc_next;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a behavioural add/subtract ALU
// alongside; expected results are hand-computed constants.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b, req_pc, req_off;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_taken;
  logic [15:0] resp_next_pc;
  logic        alu_inst_id;
  logic [15:0] alu_in0, alu_in1;
  logic        alu_reset;
  logic [15:0] alu_out, alu_zero, alu_pos;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(16), .PC_STEP(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_pc       (req_pc),
    .req_off      (req_off),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_taken   (resp_taken),
    .resp_next_pc (resp_next_pc),
    .alu_inst_id  (alu_inst_id),
    .alu_in0      (alu_in0),
    .alu_in1      (alu_in1),
    .alu_reset    (alu_reset),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_pos      (alu_pos)
  );

  // External 16-bit add/subtract ALU
  always_comb begin
    alu_out  = alu_inst_id ? (alu_in0 - alu_in1) : (alu_in0 + alu_in1);
    alu_zero = {15'd0, (alu_out == 16'd0)};
    alu_pos  = {15'd0, (alu_out != 16'd0) && !alu_out[15]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] pc, input logic [15:0] off);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_pc    = pc;
    req_off   = off;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic await_resp(input string tag, input int exp_lat, input logic exp_taken,
                            input logic [15:0] exp_pc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 10);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " taken"}, resp_taken, exp_taken);
    check({tag, " next_pc"}, resp_next_pc, exp_pc);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] pc, input logic [15:0] off,
                        input logic exp_taken, input logic [15:0] exp_pc, input int exp_lat);
    send(op, a, b, pc, off);
    await_resp(tag, exp_lat, exp_taken, exp_pc);
    handshake();
    $display("txn %s op=%0d a=%h b=%h pc=%h off=%h -> taken=%0b next_pc=%h",
             tag, op, a, b, pc, off, resp_taken, resp_next_pc);
  endtask

  logic [2:0]  sweep_tbl [8];
  logic [15:0] sweep_a   [3];
  logic [15:0] sweep_b   [3];

  initial begin
    logic stale;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_a      = 16'd0;
    req_b      = 16'd0;
    req_pc     = 16'd0;
    req_off    = 16'd0;
    resp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("alu_reset follows reset", alu_reset, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("reset req_ready", req_ready, 1'b1);
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset resp_taken", resp_taken, 1'b0);
    check("reset resp_next_pc", resp_next_pc, 16'h0000);
    check("reset alu_inst_id", alu_inst_id, 1'b0);
    check("reset alu_in0", alu_in0, 16'h0000);
    check("reset alu_in1", alu_in1, 16'h0000);

    // Plan vectors
    do_req("beq_eq", BR_BEQ, 16'd5, 16'd5, 16'h0010, 16'h0004, 1'b1, 16'h0014, 3);
    do_req("blt", BR_BLT, 16'd3, 16'd7, 16'h0020, 16'hFFF0, 1'b1, 16'h0010, 3);
    do_req("bgt", BR_BGT, 16'd3, 16'd7, 16'h0020, 16'hFFF0, 1'b0, 16'h0021, 3);
    do_req("jmp_wrap", BR_JMP, 16'd0, 16'd0, 16'hFFFE, 16'h0003, 1'b1, 16'h0001, 2);
    do_req("nop_wrap", BR_NOP, 16'd0, 16'd0, 16'hFFFF, 16'h0003, 1'b0, 16'h0000, 2);
    do_req("bgt_ovf", BR_BGT, 16'h8000, 16'h0001, 16'h0000, 16'h0010, 1'b1, 16'h0010, 3);
    do_req("blt_ovf", BR_BLT, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0010, 1'b1, 16'h0010, 3);

    // ALU drive during compare and target passes
    send(BR_BNE, 16'h1234, 16'h0034, 16'h0400, 16'h0020);
    @(negedge clk);
    check("cmp alu_inst_id", alu_inst_id, 1'b1);
    check("cmp alu_in0", alu_in0, 16'h1234);
    check("cmp alu_in1", alu_in1, 16'h0034);
    @(negedge clk);
    check("tgt alu_inst_id", alu_inst_id, 1'b0);
    check("tgt alu_in0", alu_in0, 16'h0400);
    check("tgt alu_in1", alu_in1, 16'h0020);
    await_resp("bne_drive", 1, 1'b1, 16'h0420);
    handshake();
    @(negedge clk);
    check("resp alu_in0 idle", alu_in0, 16'h0000);

    // Backpressure: response held, second request waits for the handshake
    send(BR_BNE, 16'd1, 16'd2, 16'h0200, 16'h0008);
    await_resp("bp_first", 3, 1'b1, 16'h0208);
    req_valid = 1'b1;
    req_op    = BR_BEQ;
    req_a     = 16'd0;
    req_b     = 16'd0;
    req_pc    = 16'h0300;
    req_off   = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp hold%0d resp_valid", i), resp_valid, 1'b1);
      check($sformatf("bp hold%0d taken", i), resp_taken, 1'b1);
      check($sformatf("bp hold%0d next_pc", i), resp_next_pc, 16'h0208);
      check($sformatf("bp hold%0d req_ready", i), req_ready, 1'b0);
    end
    handshake();
    @(negedge clk);
    check("bp idle req_ready", req_ready, 1'b1);
    check("bp idle resp_valid", resp_valid, 1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    await_resp("bp_second", 3, 1'b1, 16'h0310);
    handshake();
    $display("txn backpressure second request resolved next_pc=%h", resp_next_pc);

    // Reset during CMP
    send(BR_BEQ, 16'd5, 16'd5, 16'h0010, 16'h0004);
    @(negedge clk);
    check("rst_cmp in CMP", alu_inst_id, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_cmp req_ready", req_ready, 1'b1);
    check("rst_cmp resp_valid", resp_valid, 1'b0);
    check("rst_cmp alu_inst_id", alu_inst_id, 1'b0);
    check("rst_cmp alu_in0", alu_in0, 16'h0000);
    check("rst_cmp alu_in1", alu_in1, 16'h0000);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stale = stale | resp_valid;
    end
    check("rst_cmp no stale resp", stale, 1'b0);
    $display("txn reset during CMP discarded request");

    // Sweep: bits [2:0] = outcome for (1,1), (2,1), (1,2)
    sweep_a[0] = 16'd1; sweep_b[0] = 16'd1;
    sweep_a[1] = 16'd2; sweep_b[1] = 16'd1;
    sweep_a[2] = 16'd1; sweep_b[2] = 16'd2;
    sweep_tbl[0] = 3'b100;  // BEQ
    sweep_tbl[1] = 3'b011;  // BNE
    sweep_tbl[2] = 3'b010;  // BGT
    sweep_tbl[3] = 3'b001;  // BLT
    sweep_tbl[4] = 3'b110;  // BGE
    sweep_tbl[5] = 3'b101;  // BLE
    sweep_tbl[6] = 3'b111;  // JMP
    sweep_tbl[7] = 3'b000;  // NOP
    for (int o = 0; o < 8; o++) begin
      for (int p = 0; p < 3; p++) begin
        logic [2:0] row;
        logic       exp_t;
        row   = sweep_tbl[o];
        exp_t = row[2-p];
        do_req($sformatf("sweep op%0d pair%0d", o, p), 3'(o), sweep_a[p], sweep_b[p],
               16'h0100, 16'h0040, exp_t, exp_t ? 16'h0140 : 16'h0101, (o < 6) ? 3 : 2);
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Initiator-side controller for the 16-bit add/subtract ALU (alu_component).
- Accepts branch requests over a valid/ready handshake and drives the ALU port set (inst_id, in0, in1, reset).
- Uses two ALU passes: a subtract to compare operands, then an add to form the target PC. Samples out/zero/pos on each pass.
- Returns taken/not-taken and the next PC over a valid/ready response channel. Sits between decode and PC update.

Parameters:
- WIDTH, 16, datapath/PC width; must match the ALU (16).
- PC_STEP, 1, fall-through increment added to pc.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_op  input  3  condition code (see Behaviour).
- req_a  input  16  compare operand A.
- req_b  input  16  compare operand B.
- req_pc  input  16  current PC.
- req_off  input  16  branch offset, two's complement.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_taken  output  1  branch taken.
- resp_next_pc  output  16  target if taken, else pc+PC_STEP (mod 2^16).
- alu_inst_id  output  1  0 = add, 1 = subtract.
- alu_in0  output  16  ALU operand 0.
- alu_in1  output  16  ALU operand 1.
- alu_reset  output  1  driven equal to reset.
- alu_out  input  16  ALU result.
- alu_zero  input  16  ALU zero flag; only bit 0 used.
- alu_pos  input  16  ALU positive flag (result nonzero with bit15 = 0); only bit 0 used.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. On reset: state = IDLE; all outputs 0 except req_ready = 1; latched fields cleared.
- Condition codes:
  - 000 BEQ: zero.
  - 001 BNE: !zero.
  - 010 BGT: pos.
  - 011 BLT: !zero & !pos.
  - 100 BGE: zero | pos.
  - 101 BLE: !pos.
  - 110 JMP: always taken.
  - 111 NOP: never taken.
- Compare is sign of the wrapped 16-bit difference a-b. Signed overflow is not corrected (e.g. a=0x7FFF, b=0xFFFF gives BLT taken).
- States: IDLE, CMP, TGT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch op/a/b/pc/off.
  - Next state: TGT if op is JMP or NOP, otherwise CMP.
- CMP: drive alu_inst_id = 1, alu_in0 = a, alu_in1 = b. At the clock edge, latch zero[0] and pos[0] into flag registers, then go to TGT.
- TGT:
  - Drive alu_inst_id = 0, alu_in0 = pc, alu_in1 = off.
  - At the clock edge, evaluate taken from the latched flags and latch next_pc = taken ? alu_out : pc+PC_STEP.
  - Go to RESP.
- RESP: resp_valid = 1; resp_taken/resp_next_pc held stable. On resp_ready, go to IDLE.
- req_ready is low outside IDLE. A new request is only accepted the cycle after the response handshake (no bypass).
- In IDLE and RESP, ALU outputs are driven to 0 (inst_id = 0).
- Latency: request accepted at edge N. Conditional ops raise resp_valid in the cycle after edge N+2; JMP/NOP after edge N+1.
- Throughput: 1 request per 4 cycles (3 for JMP/NOP) with resp_ready held high.
- resp_ready while resp_valid is low is ignored.
- Wrap-around: pc+off and pc+PC_STEP are modulo 2^16.
- Reset mid-operation (any state): in-flight request discarded, no response produced, IDLE next cycle.
- Flag registers are not updated for JMP/NOP. Their stale values are never used.

Decomposition:
- Shared package: WIDTH constant, 3-bit condition-code encodings (BR_BEQ..BR_NOP), ALU op encodings (ALU_ADD = 0, ALU_SUB = 1), state encoding.
- One natural sub-module: br_cond_eval, a combinational map from (op, zero, pos) to taken.
- The ALU is instantiated externally (alongside) and is not inside this block.

Test Plan:
- Reset, then BEQ a=5, b=5, pc=0x0010, off=0x0004 → resp_valid 3 cycles after accept; taken = 1; next_pc = 0x0014.
- BLT a=3, b=7, pc=0x0020, off=0xFFF0 → taken = 1, next_pc = 0x0010. Repeat with BGT → taken = 0, next_pc = 0x0021.
- JMP pc=0xFFFE, off=0x0003 → resp_valid 2 cycles after accept; taken = 1; next_pc = 0x0001 (wrap). NOP pc=0xFFFF → taken = 0, next_pc = 0x0000.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP → resp_valid and data stable, req_ready = 0, a second req_valid is not accepted until the cycle after the response handshake.
- Assert reset during CMP → next cycle req_ready = 1, resp_valid = 0, all ALU outputs 0; no stale response appears later.
- Sweep all 8 op codes with (a,b) in {(1,1), (2,1), (1,2)} → taken matches the condition table; overflow case a=0x8000, b=0x0001 with BGT → taken = 1.
